// File: rtl/centered_variable_node_accumulate_pkg.sv
// -----------------------------------------------------------------------------
// centered_variable_node_accumulate_pkg
// Shared definitions for the centered ADMM-LP decoder datapath stages.
//   - Fixed-point constants: DATA_WIDTH, FRACTION_WIDTH, ONE (1.0).
//   - Default tag and degree widths.
//   - FSM state encoding of the variable-node accumulate stage.
//   - sat_data(): clamps a wide signed value to the DATA_WIDTH range. It is
//     shared by the variable-node, penalty and projection stages.
// No ports (package).
// -----------------------------------------------------------------------------
package centered_variable_node_accumulate_pkg;

   localparam int DATA_WIDTH     = 18;
   localparam int FRACTION_WIDTH = 10;
   localparam int TAG_WIDTH      = 32;
   localparam int DEG_WIDTH      = 5;
   localparam int ONE            = 1 << FRACTION_WIDTH;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_ACCUM = 3'd1;
   localparam logic [2:0] ST_MUL   = 3'd2;
   localparam logic [2:0] ST_SAT   = 3'd3;
   localparam logic [2:0] ST_OUT   = 3'd4;

   // Clamp to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1] of the shared data width.
   function automatic logic signed [DATA_WIDTH-1:0] sat_data(input logic signed [63:0] value);
      logic signed [63:0] max_v;
      logic signed [63:0] min_v;
      logic signed [63:0] clamped;
      max_v = (64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1;
      min_v = -(64'sd1 <<< (DATA_WIDTH - 1));
      if (value > max_v)
         clamped = max_v;
      else if (value < min_v)
         clamped = min_v;
      else
         clamped = value;
      return clamped[DATA_WIDTH-1:0];
   endfunction

endpackage

// File: rtl/centered_variable_node_accumulate_if.sv
// -----------------------------------------------------------------------------
// centered_variable_node_accumulate_if
// Message-beat input stream and result output stream of the variable-node
// accumulate stage.
//   Input stream : valid_in / ready_out, tag_in, degree, recip_degree, llr, msg
//   Output stream: valid_out / ready_in, tag_out, prePenalty
// Modports:
//   slave  - the accumulate stage itself.
//   master - its environment (message producer and the L1 penalty consumer).
// -----------------------------------------------------------------------------
interface centered_variable_node_accumulate_if #(
   parameter int TAG_WIDTH      = centered_variable_node_accumulate_pkg::TAG_WIDTH,
   parameter int DATA_WIDTH     = centered_variable_node_accumulate_pkg::DATA_WIDTH,
   parameter int FRACTION_WIDTH = centered_variable_node_accumulate_pkg::FRACTION_WIDTH,
   parameter int DEG_WIDTH      = centered_variable_node_accumulate_pkg::DEG_WIDTH
) ();

   logic                         valid_in;
   logic                         ready_out;
   logic [TAG_WIDTH-1:0]         tag_in;
   logic [DEG_WIDTH-1:0]         degree;
   logic [FRACTION_WIDTH:0]      recip_degree;
   logic signed [DATA_WIDTH-1:0] llr;
   logic signed [DATA_WIDTH-1:0] msg;

   logic                         valid_out;
   logic                         ready_in;
   logic [TAG_WIDTH-1:0]         tag_out;
   logic signed [DATA_WIDTH-1:0] prePenalty;

   modport master (
      output valid_in, tag_in, degree, recip_degree, llr, msg, ready_in,
      input  ready_out, valid_out, tag_out, prePenalty
   );

   modport slave (
      input  valid_in, tag_in, degree, recip_degree, llr, msg, ready_in,
      output ready_out, valid_out, tag_out, prePenalty
   );

endinterface

// File: rtl/centered_variable_node_accumulate_fixed_mul_sat.sv
// -----------------------------------------------------------------------------
// fixed_mul_sat
// Two-stage registered arithmetic: prod = (acc - llr) * recip on mul_en, then
// res = sat(prod >>> FRACTION_WIDTH) on sat_en. Both registers hold when their
// enable is low.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   mul_en       : load the product register
//   sat_en       : load the shifted/saturated result register
//   acc          : signed message sum
//   llr          : signed scaled channel LLR
//   recip        : unsigned Q1.F reciprocal of the degree
//   res          : signed saturated result
// -----------------------------------------------------------------------------
module fixed_mul_sat #(
   parameter int DATA_WIDTH     = centered_variable_node_accumulate_pkg::DATA_WIDTH,
   parameter int FRACTION_WIDTH = centered_variable_node_accumulate_pkg::FRACTION_WIDTH,
   parameter int ACC_WIDTH      = 24
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         mul_en,
   input  logic                         sat_en,
   input  logic signed [ACC_WIDTH-1:0]  acc,
   input  logic signed [DATA_WIDTH-1:0] llr,
   input  logic [FRACTION_WIDTH:0]      recip,
   output logic signed [DATA_WIDTH-1:0] res
);

   import centered_variable_node_accumulate_pkg::*;

   localparam int DIFF_WIDTH = ACC_WIDTH + 1;
   // Signed diff times a zero-extended (one extra bit) unsigned reciprocal.
   localparam int PROD_WIDTH = DIFF_WIDTH + FRACTION_WIDTH + 2;

   logic signed [DIFF_WIDTH-1:0] diff;
   logic signed [PROD_WIDTH-1:0] prod_d;
   logic signed [PROD_WIDTH-1:0] prod_q;
   logic signed [63:0]           shifted;

   assign diff    = DIFF_WIDTH'(acc) - DIFF_WIDTH'(llr);
   assign prod_d  = PROD_WIDTH'(diff) * PROD_WIDTH'($signed({1'b0, recip}));
   // Arithmetic shift floors toward minus infinity for negative products.
   assign shifted = 64'(prod_q >>> FRACTION_WIDTH);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prod_q <= '0;
         res    <= '0;
      end else begin
         if (mul_en)
            prod_q <= prod_d;
         if (sat_en)
            res <= sat_data(shifted);
      end
   end

endmodule

// File: rtl/centered_variable_node_accumulate.sv
// -----------------------------------------------------------------------------
// centered_variable_node_accumulate
// Serial variable-node update: sums `degree` check-to-variable messages (one
// per accepted beat), subtracts the node's scaled LLR, multiplies by the
// supplied reciprocal of the degree and presents one saturated, tagged
// prePenalty value to the L1 penalty stage.
// Ports:
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : slave side of the beat/result streams
//   busy    : high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module centered_variable_node_accumulate #(
   parameter int TAG_WIDTH      = centered_variable_node_accumulate_pkg::TAG_WIDTH,
   parameter int DATA_WIDTH     = centered_variable_node_accumulate_pkg::DATA_WIDTH,
   parameter int FRACTION_WIDTH = centered_variable_node_accumulate_pkg::FRACTION_WIDTH,
   parameter int DEG_WIDTH      = centered_variable_node_accumulate_pkg::DEG_WIDTH
) (
   input  logic                             clk,
   input  logic                             reset_n,
   centered_variable_node_accumulate_if.slave bus,
   output logic                             busy
);

   import centered_variable_node_accumulate_pkg::*;

   // Wide enough for (2^DEG_WIDTH - 1) full-scale messages without overflow.
   localparam int ACC_WIDTH = DATA_WIDTH + DEG_WIDTH + 1;

   logic [2:0]                   state_q;
   logic [2:0]                   state_d;
   logic signed [ACC_WIDTH-1:0]  acc_q;
   logic signed [ACC_WIDTH-1:0]  msg_ext;
   logic [DEG_WIDTH-1:0]         cnt_q;
   logic [DEG_WIDTH-1:0]         cnt_inc;
   logic [DEG_WIDTH-1:0]         degree_q;
   logic [FRACTION_WIDTH:0]      recip_q;
   logic signed [DATA_WIDTH-1:0] llr_q;
   logic [TAG_WIDTH-1:0]         tag_q;
   logic signed [DATA_WIDTH-1:0] res;
   logic                         beat;

   assign bus.ready_out  = (state_q == ST_IDLE) || (state_q == ST_ACCUM);
   assign bus.valid_out  = (state_q == ST_OUT);
   assign bus.tag_out    = tag_q;
   assign bus.prePenalty = res;
   assign busy           = (state_q != ST_IDLE);

   assign beat    = bus.valid_in && bus.ready_out;
   assign msg_ext = ACC_WIDTH'($signed(bus.msg));
   assign cnt_inc = cnt_q + DEG_WIDTH'(1);

   always_comb begin
      // NOTE: default first so every path assigns state_d and no latch is inferred.
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            // Degree 0 and 1 both mean a single beat.
            if (beat)
               state_d = (bus.degree <= DEG_WIDTH'(1)) ? ST_MUL : ST_ACCUM;
         end
         ST_ACCUM: begin
            if (beat && (cnt_inc == degree_q))
               state_d = ST_MUL;
         end
         ST_MUL:  state_d = ST_SAT;
         ST_SAT:  state_d = ST_OUT;
         ST_OUT: begin
            if (bus.ready_in)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values.
         state_q <= state_d;
      end
   end

   // Node context is captured on the first beat only; later beats only add.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: datapath registers are reset too, so a mid-node reset leaves no stale sum or tag.
         acc_q    <= '0;
         cnt_q    <= '0;
         degree_q <= '0;
         recip_q  <= '0;
         llr_q    <= '0;
         tag_q    <= '0;
      end else if (beat) begin
         if (state_q == ST_IDLE) begin
            acc_q    <= msg_ext;
            cnt_q    <= DEG_WIDTH'(1);
            degree_q <= bus.degree;
            recip_q  <= bus.recip_degree;
            llr_q    <= bus.llr;
            tag_q    <= bus.tag_in;
         end else begin
            acc_q <= acc_q + msg_ext;
            cnt_q <= cnt_inc;
         end
      end
   end

   fixed_mul_sat #(
      .DATA_WIDTH     (DATA_WIDTH),
      .FRACTION_WIDTH (FRACTION_WIDTH),
      .ACC_WIDTH      (ACC_WIDTH)
   ) u_mul_sat (
      .clk     (clk),
      .reset_n (reset_n),
      .mul_en  (state_q == ST_MUL),
      .sat_en  (state_q == ST_SAT),
      .acc     (acc_q),
      .llr     (llr_q),
      .recip   (recip_q),
      .res     (res)
   );

endmodule

// File: tb/tb_centered_variable_node_accumulate.sv
// -----------------------------------------------------------------------------
// tb_centered_variable_node_accumulate
// Self-checking bench for centered_variable_node_accumulate. Inputs change on
// the falling edge, outputs are sampled on the falling edge. Expected results
// come from a plain-arithmetic model of sum, subtract, multiply, floor, clamp.
// -----------------------------------------------------------------------------
module tb_centered_variable_node_accumulate;

   localparam int DW      = 18;
   localparam int FW      = 10;
   localparam int TIMEOUT = 100;

   logic clk = 1'b0;
   logic reset_n;
   logic busy;

   int checks = 0;
   int errors = 0;
   int msg_q[$];

   always #5 clk = ~clk;

   centered_variable_node_accumulate_if bus ();

   centered_variable_node_accumulate dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus),
      .busy    (busy)
   );

   // Reference: floor(((sum of msgs) - llr) * recip / 2^FW), clamped to DW bits.
   function automatic longint model_result(input longint llr_v, input longint recip_v);
      longint sum;
      longint prod;
      longint r;
      sum = 0;
      foreach (msg_q[i]) sum += msg_q[i];
      prod = (sum - llr_v) * recip_v;
      r = prod >>> FW;
      if (r > 131071) r = 131071;
      if (r < -131072) r = -131072;
      return r;
   endfunction

   function automatic int rand_data();
      return int'($urandom_range(0, 262143)) - 131072;
   endfunction

   // Presents one beat from a falling edge, waits for ready_out, returns on the
   // falling edge after the accepting rising edge with valid_in low.
   task automatic send_beat(input int msg_v, input int deg, input int recip,
                            input int llr_v, input logic [31:0] tag);
      int waited;
      waited = 0;
      bus.valid_in     = 1'b1;
      bus.msg          = msg_v[DW-1:0];
      bus.degree       = deg[4:0];
      bus.recip_degree = recip[FW:0];
      bus.llr          = llr_v[DW-1:0];
      bus.tag_in       = tag;
      while (!bus.ready_out && waited < TIMEOUT) begin
         @(negedge clk);
         waited++;
      end
      checks++;
      if (waited >= TIMEOUT) begin
         errors++;
         $display("FAIL beat_accept: ready_out never rose within %0d cycles", TIMEOUT);
      end
      @(negedge clk);
      bus.valid_in = 1'b0;
   endtask

   // Runs one node from msg_q; later beats carry junk context fields, which must
   // be ignored. stall = cycles ready_in is held low while the output is valid.
   task automatic run_node(input string name, input int deg, input int recip,
                           input int llr_v, input logic [31:0] tag, input int stall);
      int beats;
      int waited;
      longint exp_l;
      logic signed [DW-1:0] exp_v;
      beats  = (deg <= 1) ? 1 : deg;
      exp_l  = model_result(longint'(llr_v), longint'(recip));
      exp_v  = exp_l[DW-1:0];
      bus.ready_in = (stall == 0);
      for (int i = 0; i < beats; i++) begin
         if (i == 0)
            send_beat(msg_q[i], deg, recip, llr_v, tag);
         else
            send_beat(msg_q[i], int'($urandom), int'($urandom), int'($urandom), $urandom);
      end
      waited = 0;
      while (!bus.valid_out && waited < TIMEOUT) begin
         @(negedge clk);
         waited++;
      end
      checks++;
      if (waited != 2) begin
         errors++;
         $display("FAIL %s latency: valid_out after %0d cycles, required 2", name, waited);
      end
      checks++;
      if (bus.prePenalty !== exp_v) begin
         errors++;
         $display("FAIL %s result: got %0d, required %0d", name, bus.prePenalty, exp_v);
      end
      checks++;
      if (bus.tag_out !== tag) begin
         errors++;
         $display("FAIL %s tag: got %h, required %h", name, bus.tag_out, tag);
      end
      checks++;
      if (bus.ready_out !== 1'b0) begin
         errors++;
         $display("FAIL %s ready_in_out: ready_out %b while valid_out, required 0", name, bus.ready_out);
      end
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         checks++;
         if (bus.valid_out !== 1'b1 || bus.ready_out !== 1'b0 ||
             bus.prePenalty !== exp_v || bus.tag_out !== tag) begin
            errors++;
            $display("FAIL %s hold[%0d]: valid %b ready %b result %0d tag %h, required 1 0 %0d %h",
                     name, s, bus.valid_out, bus.ready_out, bus.prePenalty, bus.tag_out, exp_v, tag);
         end
      end
      bus.ready_in = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.valid_out !== 1'b0 || bus.ready_out !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL %s release: valid %b ready %b busy %b, required 0 1 0",
                  name, bus.valid_out, bus.ready_out, busy);
      end
   endtask

   task automatic check_reset_values(input string name);
      checks++;
      if (bus.valid_out !== 1'b0 || bus.ready_out !== 1'b1 || busy !== 1'b0 ||
          bus.prePenalty !== '0 || bus.tag_out !== '0) begin
         errors++;
         $display("FAIL %s: valid %b ready %b busy %b result %0d tag %h, required 0 1 0 0 0",
                  name, bus.valid_out, bus.ready_out, busy, bus.prePenalty, bus.tag_out);
      end
   endtask

   task automatic test_reset();
      reset_n          = 1'b0;
      bus.valid_in     = 1'b0;
      bus.ready_in     = 1'b1;
      bus.msg          = '0;
      bus.degree       = '0;
      bus.recip_degree = '0;
      bus.llr          = '0;
      bus.tag_in       = '0;
      @(negedge clk);
      @(negedge clk);
      check_reset_values("reset_state");
      reset_n = 1'b1;
      @(negedge clk);
      check_reset_values("after_release");
   endtask

   task automatic test_nominal();
      msg_q = '{512, 256, -256};
      run_node("nominal", 3, 341, 200, 32'hCAFE_0001, 0);
   endtask

   task automatic test_floor();
      msg_q = '{-1, 0};
      run_node("floor_neg", 2, 512, 0, 32'h0000_F100, 0);
   endtask

   task automatic test_saturation();
      msg_q = '{131071};
      run_node("sat_pos", 1, 1024, -131072, 32'h5A70_0001, 0);
      msg_q = '{-131072};
      run_node("sat_neg", 1, 1024, 131071, 32'h5A70_0002, 0);
   endtask

   // A single-beat node while the next beat is already waiting on valid_in.
   task automatic test_degree_one();
      logic signed [DW-1:0] exp_a;
      logic signed [DW-1:0] exp_b;
      longint tmp;
      msg_q = '{300};
      tmp   = model_result(50, 1024);
      exp_a = tmp[DW-1:0];
      msg_q = '{777};
      tmp   = model_result(7, 1024);
      exp_b = tmp[DW-1:0];
      bus.ready_in = 1'b1;
      send_beat(300, 0, 1024, 50, 32'hDE60_0000);
      bus.valid_in     = 1'b1;
      bus.msg          = 18'sd777;
      bus.degree       = 5'd1;
      bus.recip_degree = 11'd1024;
      bus.llr          = 18'sd7;
      bus.tag_in       = 32'hDE60_0001;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (bus.ready_out !== 1'b0) begin
            errors++;
            $display("FAIL deg0_blocked[%0d]: ready_out %b, required 0", i, bus.ready_out);
         end
         if (i < 2) @(negedge clk);
      end
      checks++;
      if (bus.valid_out !== 1'b1 || bus.prePenalty !== exp_a || bus.tag_out !== 32'hDE60_0000) begin
         errors++;
         $display("FAIL deg0_result: valid %b result %0d tag %h, required 1 %0d de600000",
                  bus.valid_out, bus.prePenalty, bus.tag_out, exp_a);
      end
      @(negedge clk);
      checks++;
      if (bus.ready_out !== 1'b1 || bus.valid_out !== 1'b0) begin
         errors++;
         $display("FAIL deg1_ready: ready %b valid %b, required 1 0", bus.ready_out, bus.valid_out);
      end
      @(negedge clk);
      bus.valid_in = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (bus.valid_out !== 1'b1 || bus.prePenalty !== exp_b || bus.tag_out !== 32'hDE60_0001) begin
         errors++;
         $display("FAIL deg1_result: valid %b result %0d tag %h, required 1 %0d de600001",
                  bus.valid_out, bus.prePenalty, bus.tag_out, exp_b);
      end
      @(negedge clk);
      checks++;
      if (bus.valid_out !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL deg1_release: valid %b busy %b, required 0 0", bus.valid_out, busy);
      end
   endtask

   task automatic test_backpressure();
      msg_q = {};
      for (int i = 0; i < 4; i++) msg_q.push_back(rand_data());
      run_node("backpressure", 4, 256, rand_data(), 32'hBAC4_0000, 5);
   endtask

   task automatic test_reset_mid_accum();
      bus.ready_in = 1'b1;
      send_beat(40000, 4, 256, 10, 32'h57A1_E000);
      send_beat(50000, 0, 0, 0, 32'h0);
      reset_n = 1'b0;
      #1;
      check_reset_values("reset_mid_accum");
      @(negedge clk);
      reset_n = 1'b1;
      msg_q = '{1000, -300};
      run_node("after_reset", 2, 512, 100, 32'hF2E5_0002, 0);
   endtask

   task automatic test_random();
      int deg;
      int recip;
      for (int n = 0; n < 30; n++) begin
         deg = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 6));
         if ($urandom_range(0, 1) == 0)
            recip = (deg <= 1) ? 1024 : 1024 / deg;
         else
            recip = int'($urandom_range(0, 2047));
         msg_q = {};
         for (int i = 0; i < ((deg <= 1) ? 1 : deg); i++) msg_q.push_back(rand_data());
         run_node($sformatf("random%0d", n), deg, recip, rand_data(), $urandom,
                  int'($urandom_range(0, 3)));
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_floor();
      test_saturation();
      test_degree_one();
      test_backpressure();
      test_reset_mid_accum();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
